ahb_region_sel: RTL

- Downstream consumer of the physical-address region decoder's one-hot SelRegions vector in the uncore.
- Converts address-phase region hits into AHB slave selects and registers them into the data phase.
- Muxes slave responses (HRDATA/HREADYOUT/HRESP) back to the bus master.
- Contains the AHB default slave, which returns the two-cycle ERROR response for unmapped addresses.

---
 rtl/ahb_region_sel_pkg.sv | 5 +
 rtl/ahb_region_sel_default_slave.sv | 25 ++
 rtl/ahb_region_sel.sv | 72 +++++++
 3 files changed

// File: rtl/ahb_region_sel_pkg.sv
// ahb_region_sel_pkg: shared AHB constants and default-slave state encoding.
package ahb_region_sel_pkg;
   typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} dsstate_t;
   localparam logic [1:0] AHB_HTRANS_NONSEQ = 2'b10;
endpackage

// File: rtl/ahb_region_sel_default_slave.sv
// ahb_default_slave: two-cycle AHB ERROR response for accesses that hit no region.
module ahb_default_slave
   import ahb_region_sel_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic AccUnmapped,
   output logic HREADYDS,
   output logic HRESPDS
);
   dsstate_t r_state;
   dsstate_t w_next;
   always_ff @(posedge clk)
      if (reset) r_state <= DS_IDLE;
      else       r_state <= w_next;
   // ERR2 is itself an address-phase cycle, so a new unmapped access re-enters ERR1 directly
   always_comb begin
      w_next   = r_state;
      HREADYDS = 1'b1;
      HRESPDS  = 1'b0;
      w_next   = (r_state == DS_ERR1) ? DS_ERR2 : AccUnmapped ? DS_ERR1 : DS_IDLE;
      HREADYDS = (r_state != DS_ERR1);
      HRESPDS  = (r_state != DS_IDLE);
   end
endmodule

// File: rtl/ahb_region_sel.sv
// ahb_region_sel: priority slave select from region hits, data-phase select register
// and slave response mux, with the built-in default slave for unmapped addresses.
module ahb_region_sel
   import ahb_region_sel_pkg::*;
#(
   parameter int XLEN = 64,
   parameter int NREG = 13
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [1:0]               HTRANS,
   input  logic [NREG-1:0]          SelRegions,
   input  logic [NREG-2:0]          HREADYOUTS,
   input  logic [NREG-2:0]          HRESPS,
   input  logic [(NREG-1)*XLEN-1:0] HRDATAS,
   output logic [NREG-2:0]          HSEL,
   output logic [NREG-1:0]          HSELD,
   output logic                     HREADY,
   output logic                     HRESP,
   output logic [XLEN-1:0]          HRDATA
);
   logic [NREG-2:0] w_hits;
   logic [NREG-2:0] w_lowest;
   logic            w_acc;
   logic            w_mapped;
   logic            w_acc_unmapped;
   logic            w_hreadyds;
   logic            w_hrespds;
   logic            w_hready;
   logic            w_hresp;
   logic [XLEN-1:0] w_hrdata;
   logic            w_unused;
   logic [NREG-1:0] r_hseld;
   // bit 0 of SelRegions is redundant: unmapped is recomputed from the slave hits
   assign w_unused       = SelRegions[0];
   assign w_hits         = SelRegions[NREG-1:1];
   assign w_lowest       = w_hits & (-w_hits);
   assign w_mapped       = |w_hits;
   assign w_acc          = |(HTRANS & AHB_HTRANS_NONSEQ) & w_hready;
   assign w_acc_unmapped = w_acc & ~w_mapped;
   assign HSEL           = w_acc ? w_lowest : '0;
   always_ff @(posedge clk)
      if (reset)         r_hseld <= '0;
      else if (w_hready) r_hseld <= {HSEL, w_acc_unmapped};
   ahb_default_slave u_ds (
      .clk         (clk),
      .reset       (reset),
      .AccUnmapped (w_acc_unmapped),
      .HREADYDS    (w_hreadyds),
      .HRESPDS     (w_hrespds)
   );
   always_comb begin
      w_hready = 1'b1;
      w_hresp  = 1'b0;
      w_hrdata = '0;
      if (r_hseld[0]) begin
         w_hready = w_hreadyds;
         w_hresp  = w_hrespds;
      end
      for (int i = 1; i < NREG; i++)
         if (r_hseld[i]) begin
            w_hready = HREADYOUTS[i-1];
            w_hresp  = HRESPS[i-1];
            w_hrdata = HRDATAS[(i-1)*XLEN +: XLEN];
         end
   end
   assign HSELD  = r_hseld;
   assign HREADY = w_hready;
   assign HRESP  = w_hresp;
   assign HRDATA = w_hrdata;
   a_hseld_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(r_hseld));
endmodule
